// File: rtl/axi_rd_slave_pkg.sv
// Shared AXI read-channel definitions: response and burst codes, plus the
// bus-width helper used by the read slave and its address generator.
package axi_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // log2 of the bus width in bytes, i.e. the largest legal ar_size.
  function automatic int unsigned bus_size_log2(input int unsigned bus_w);
    return $clog2(bus_w / 8);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts.
// WRAP support is compiled in only when AXI_RD_SLAVE_WRAP_EN is defined.
module axi_burst_addr
  import axi_rd_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [3:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] size_bytes;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_next;

  assign size_bytes = ADDR_W'(1) << size_i;
  assign aligned    = addr_i & ~(size_bytes - ADDR_W'(1));
  assign incr       = aligned + size_bytes;

`ifdef AXI_RD_SLAVE_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;

  // Boundary is (len+1) beats; crossing it clears the low bits back to base.
  assign wrap_mask = (ADDR_W'({1'b0, len_i} + 5'd1) << size_i) - ADDR_W'(1);
  assign wrap_next = (addr_i & ~wrap_mask) | (incr & wrap_mask);
`else
  logic unused_len;

  assign unused_len = ^len_i;
  assign wrap_next  = addr_i;
`endif

  always_comb begin
    case (burst_i)
      BURST_INCR: next_addr_o = incr;
      BURST_WRAP: next_addr_o = wrap_next;
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI-3 read slave fronting a single-port word memory, one burst at a time.
// Define AXI_RD_SLAVE_WRAP_EN to support WRAP bursts; otherwise they get SLVERR.
module axi_rd_slave
  import axi_rd_slave_pkg::*;
#(
  parameter int unsigned                 AXI_RD_ID_WIDTH   = 8,
  parameter int unsigned                 AXI_RD_ADDR_WIDTH = 32,
  parameter int unsigned                 AXI_RD_BUS_WIDTH  = 32,
  parameter int unsigned                 MEM_ADDR_WIDTH    = 10,
  parameter logic [AXI_RD_ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [AXI_RD_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_RD_ADDR_WIDTH-1:0] ar_addr,
  input  logic [3:0]                   ar_len,
  input  logic [2:0]                   ar_size,
  input  logic [1:0]                   ar_burst,
  input  logic [1:0]                   ar_lock,
  input  logic [3:0]                   ar_cache,
  input  logic [2:0]                   ar_prot,
  input  logic [4:0]                   ar_user,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  output logic [AXI_RD_ID_WIDTH-1:0]   r_id,
  output logic [AXI_RD_BUS_WIDTH-1:0]  r_data,
  output logic [1:0]                   r_resp,
  output logic                         r_last,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic                         mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  input  logic [AXI_RD_BUS_WIDTH-1:0]  mem_rd_data,
  output logic [1:0]                   dbg_state
);

  localparam int unsigned     LOG2_BYTES = bus_size_log2(AXI_RD_BUS_WIDTH);
  localparam logic [2:0]      MAX_SIZE   = 3'(LOG2_BYTES);
  localparam longint unsigned MEM_BYTES  = 64'd1 << (MEM_ADDR_WIDTH + LOG2_BYTES);

  typedef enum logic [1:0] {IDLE, READ, LOAD, RESP} state_e;

  state_e                         state_q, state_d;
  logic                           ready_en_q;
  logic [AXI_RD_ID_WIDTH-1:0]     id_q, id_d;
  logic [AXI_RD_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]                     len_q, len_d;
  logic [2:0]                     size_q, size_d;
  logic [1:0]                     burst_q, burst_d;
  logic                           err_q, err_d;
  logic [3:0]                     beat_q, beat_d;
  logic [AXI_RD_BUS_WIDTH-1:0]    r_data_q, r_data_d;
  logic [1:0]                     r_resp_q, r_resp_d;
  logic [AXI_RD_ID_WIDTH-1:0]     r_id_q, r_id_d;
  logic                           r_last_q, r_last_d;

  logic [AXI_RD_ADDR_WIDTH-1:0]   next_addr;
  logic [AXI_RD_ADDR_WIDTH-1:0]   offset;
  logic                           in_range;
  logic                           beat_err;
  logic                           burst_err;
  logic                           unused_ok;

  assign unused_ok = ^{ar_lock, ar_cache, ar_prot, ar_user};

  axi_burst_addr #(.ADDR_W(AXI_RD_ADDR_WIDTH)) u_burst_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Burst-wide errors are decided once, from the AR fields, at acceptance.
  always_comb begin
    burst_err = 1'b0;
    if (ar_burst == BURST_RSVD) burst_err = 1'b1;
    if (ar_size > MAX_SIZE)     burst_err = 1'b1;
`ifdef AXI_RD_SLAVE_WRAP_EN
    if (ar_burst == BURST_WRAP && !(ar_len inside {4'd1, 4'd3, 4'd7, 4'd15}))
      burst_err = 1'b1;
`else
    if (ar_burst == BURST_WRAP) burst_err = 1'b1;
`endif
  end

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (64'(offset) < MEM_BYTES);
  assign beat_err = err_q || !in_range;

  assign ar_ready  = (state_q == IDLE) && ready_en_q;
  assign r_valid   = (state_q == RESP);
  assign r_id      = r_id_q;
  assign r_data    = r_data_q;
  assign r_resp    = r_resp_q;
  assign r_last    = r_last_q;
  assign mem_rd_en = (state_q == READ) && !beat_err;
  assign mem_addr  = (state_q == READ) ? MEM_ADDR_WIDTH'(offset >> LOG2_BYTES) : '0;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    beat_d   = beat_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_id_d   = r_id_q;
    r_last_d = r_last_q;
    case (state_q)
      IDLE: begin
        if (ar_valid && ar_ready) begin
          id_d    = ar_id;
          addr_d  = ar_addr;
          len_d   = ar_len;
          size_d  = ar_size;
          burst_d = ar_burst;
          err_d   = burst_err;
          beat_d  = 4'd0;
          state_d = READ;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        r_data_d = beat_err ? '0 : mem_rd_data;
        r_resp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
        r_id_d   = id_q;
        r_last_d = (beat_q == len_q);
        state_d  = RESP;
      end
      RESP: begin
        if (r_ready) begin
          if (r_last_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = next_addr;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready_en_q holds ar_ready low until the first clock after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_id_q     <= '0;
      r_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_id_q     <= r_id_d;
      r_last_q   <= r_last_d;
    end
  end

endmodule
